// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decoder plus an iterative RISC-V M-extension unit.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ALUOp, funct3,
//   funct7b5, funct7b0    instruction decode inputs
//   in_valid / in_ready   instruction handshake; in_ready low stalls the pipeline
//   kill                  flush of any in-flight M operation
//   src_a, src_b          rs1 / rs2 operands
//   ALUCtrl               combinational ALU operation select
//   md_sel                current instruction is an M op
//   md_busy, md_done      M unit busy / one-cycle result-valid pulse
//   md_result             M result, held until the next completion
//
// ALUCtrl encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9.
// Multiply and divide share one hi/lo register pair. Both operate on operand
// magnitudes, and the sign correction is folded into the final iteration.
module alu_ctrl_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            kill,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [3:0]      ALUCtrl,
    output logic            md_sel,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t            state_r, next_state_s;
    logic              busy_r, done_r, special_r, neg_lo_r, neg_hi_r;
    logic [2:0]        op_r;
    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   opnd_r, hi_r, lo_r, result_r;

    logic              accept_s, signed_a_s, signed_b_s, sa_s, sb_s;
    logic              div_zero_s, div_ovf_s, last_s, finish_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_val_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_diff_s, div_hi_s, div_lo_s, mul_hi_s, mul_lo_s;
    logic [XLEN-1:0]   step_hi_s, step_lo_s, quo_fix_s, rem_fix_s, final_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    assign in_ready  = ~busy_r;
    assign md_busy   = busy_r;
    assign md_done   = done_r;
    assign md_result = result_r;

    // ALU operation decode; an M instruction presents ADD to the ALU.
    always_comb begin
        ALUCtrl = ALU_ADD;
        md_sel  = 1'b0;
        case (ALUOp)
            2'b00: ALUCtrl = ALU_ADD;
            2'b01: ALUCtrl = ALU_SUB;
            2'b10: begin
                if (funct7b0) begin
                    md_sel  = 1'b1;
                    ALUCtrl = ALU_ADD;
                end else begin
                    case (funct3)
                        3'b000:  ALUCtrl = funct7b5 ? ALU_SUB : ALU_ADD;
                        3'b111:  ALUCtrl = ALU_AND;
                        3'b110:  ALUCtrl = ALU_OR;
                        3'b100:  ALUCtrl = ALU_XOR;
                        3'b001:  ALUCtrl = ALU_SLL;
                        3'b101:  ALUCtrl = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b010:  ALUCtrl = ALU_SLT;
                        3'b011:  ALUCtrl = ALU_SLTU;
                        default: ALUCtrl = ALU_ADD;
                    endcase
                end
            end
            2'b11:   ALUCtrl = ALU_ADD;
            default: ALUCtrl = ALU_ADD;
        endcase
    end

    // Operand conditioning at acceptance: signedness, magnitudes, divide corner cases.
    always_comb begin
        accept_s      = in_valid & ~busy_r & md_sel & ~kill & (state_r == IDLE);
        // Divide ops are signed when funct3[0]=0; MULHU is unsigned on both sides,
        // MULHSU only on rs2.
        signed_a_s    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        signed_b_s    = funct3[2] ? ~funct3[0] : ~funct3[1];
        sa_s          = src_a[XLEN-1] & signed_a_s;
        sb_s          = src_b[XLEN-1] & signed_b_s;
        mag_a_s       = sa_s ? (~src_a + {{(XLEN-1){1'b0}}, 1'b1}) : src_a;
        mag_b_s       = sb_s ? (~src_b + {{(XLEN-1){1'b0}}, 1'b1}) : src_b;
        div_zero_s    = (src_b == {XLEN{1'b0}});
        div_ovf_s     = ~funct3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}})
                        & (src_b == {XLEN{1'b1}});
        if (div_zero_s) begin
            special_val_s = funct3[1] ? src_a : {XLEN{1'b1}};
        end else begin
            special_val_s = funct3[1] ? {XLEN{1'b0}} : src_a;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus final fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + {1'b0, opnd_r};
        if (lo_r[0]) begin
            {mul_hi_s, mul_lo_s} = {mul_sum_s, lo_r[XLEN-1:1]};
        end else begin
            {mul_hi_s, mul_lo_s} = {1'b0, hi_r, lo_r[XLEN-1:1]};
        end
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[XLEN-1:0] - opnd_r;
        div_hi_s    = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
        div_lo_s    = {lo_r[XLEN-2:0], div_ge_s};
        if (state_r == MUL) begin
            step_hi_s = mul_hi_s;
            step_lo_s = mul_lo_s;
        end else begin
            step_hi_s = div_hi_s;
            step_lo_s = div_lo_s;
        end
        prod_s      = {mul_hi_s, mul_lo_s};
        prod_fix_s  = neg_lo_r ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
        quo_fix_s   = neg_lo_r ? (~div_lo_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_lo_s;
        rem_fix_s   = neg_hi_r ? (~div_hi_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_hi_s;
        if (state_r == MUL) begin
            final_s = (op_r[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        end else if (special_r) begin
            final_s = lo_r;
        end else begin
            final_s = op_r[1] ? rem_fix_s : quo_fix_s;
        end
        last_s      = (cnt_r == CW'(XLEN - 1));
        finish_s    = ((state_r == MUL) & last_s) | ((state_r == DIV) & (special_r | last_s));
    end

    // Next-state decode for the M-unit sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = funct3[2] ? DIV : MUL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (kill) begin
                    next_state_s = IDLE;
                end else if (finish_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register with registered busy/done flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Datapath: operand capture on accept, iteration, result capture on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'b000;
            cnt_r     <= {CW{1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            special_r <= 1'b0;
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else if (accept_s) begin
            op_r      <= funct3;
            cnt_r     <= {CW{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            neg_lo_r  <= sa_s ^ sb_s;
            neg_hi_r  <= sa_s;
            if (funct3[2]) begin
                special_r <= div_zero_s | div_ovf_s;
                opnd_r    <= mag_b_s;
                lo_r      <= (div_zero_s | div_ovf_s) ? special_val_s : mag_a_s;
            end else begin
                special_r <= 1'b0;
                opnd_r    <= mag_a_s;
                lo_r      <= mag_b_s;
            end
        end else if (((state_r == MUL) || (state_r == DIV)) && !kill) begin
            if (finish_s) begin
                result_r <= final_s;
            end else begin
                result_r <= result_r;
            end
            if (!special_r) begin
                hi_r  <= step_hi_s;
                lo_r  <= step_lo_s;
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                hi_r  <= hi_r;
                lo_r  <= lo_r;
                cnt_r <= cnt_r;
            end
        end else begin
            result_r <= result_r;
        end
    end
endmodule
